run_length_compressor: RTL and testbench

Bit-serial run-length encoder producing the compressed stream consumed by the accelerator's decompressor. It accepts 16-bit bitmap words (bit 0 first in time), emits one header word carrying the initial bit value, then one 16-bit word per run length, and flags frame end. It sits between the weight/feature-map source and the DMA write path, with valid/ready handshakes on both sides.

---
 rtl/run_length_compressor.sv | 169 ++++++++++++++++
 tb/tb_run_length_compressor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_compressor.sv
// Purpose: bit-serial run-length encoder; header word (first bit value) then one word per run, done pulse at frame end.
// Latency: header 1 cycle after first input transfer; 1 SCAN cycle per matching bit, >=1 cycle per emitted run word.
// Backpressure: while dout_valid && !dout_ready all state and outputs hold; din_ready is low whenever a word is pending.
module run_length_compressor #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic [15:0] Dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        SCAN,
        EMIT,
        SAT,
        ZERO,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [15:0]            word;
    logic [3:0]             idx;
    logic                   cur_bit;
    logic [COUNT_WIDTH-1:0] run;
    logic                   last;

    logic                   bit_now;
    logic                   in_xfer;
    logic                   out_xfer;
    logic [COUNT_WIDTH-1:0] run_next;

    // Bit under examination and handshake qualifiers.
    assign bit_now  = word[idx];
    assign in_xfer  = din_valid && din_ready;
    assign out_xfer = dout_valid && dout_ready;
    assign run_next = run + ONE;

    // Encoder FSM; all outputs are registered and only change on a transfer or a consumed bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            word       <= '0;
            idx        <= '0;
            cur_bit    <= 1'b0;
            run        <= '0;
            last       <= 1'b0;
            din_ready  <= 1'b0;
            Dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    din_ready <= 1'b1;
                    if (in_xfer) begin
                        word       <= Din;
                        last       <= din_last;
                        cur_bit    <= Din[0];
                        idx        <= '0;
                        run        <= '0;
                        din_ready  <= 1'b0;
                        Dout       <= {15'b0, Din[0]};
                        dout_valid <= 1'b1;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (out_xfer) begin
                        dout_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_now == cur_bit) begin
                        if (run == MAX) begin
                            // Counter full: close this run with MAX and a zero-length opposite run.
                            Dout       <= 16'(MAX);
                            dout_valid <= 1'b1;
                            state      <= SAT;
                        end else begin
                            run <= run_next;
                            idx <= idx + 4'd1;
                            if (idx == 4'd15) begin
                                if (last) begin
                                    Dout       <= 16'(run_next);
                                    dout_valid <= 1'b1;
                                    state      <= FLUSH;
                                end else begin
                                    din_ready <= 1'b1;
                                    state     <= LOAD;
                                end
                            end
                        end
                    end else begin
                        // Transition: emit the finished run; the bit is re-examined afterwards.
                        Dout       <= 16'(run);
                        dout_valid <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_xfer) begin
                        cur_bit    <= ~cur_bit;
                        run        <= '0;
                        dout_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SAT: begin
                    if (out_xfer) begin
                        Dout  <= '0;
                        state <= ZERO;
                    end
                end
                ZERO: begin
                    if (out_xfer) begin
                        run        <= '0;
                        dout_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                LOAD: begin
                    // Run length and polarity carry across word boundaries.
                    if (in_xfer) begin
                        word      <= Din;
                        last      <= din_last;
                        idx       <= '0;
                        din_ready <= 1'b0;
                        state     <= SCAN;
                    end
                end
                FLUSH: begin
                    if (out_xfer) begin
                        dout_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    din_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    din_ready  <= 1'b0;
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_length_compressor.sv
module tb_run_length_compressor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Din;
    logic        din_valid;
    logic        din_last;
    logic        dout_ready;
    bit          sel;

    logic        din_valid_a, dout_ready_a, din_ready_a, dout_valid_a, done_a;
    logic        din_valid_b, dout_ready_b, din_ready_b, dout_valid_b, done_b;
    logic [15:0] dout_a, dout_b;

    logic        m_drdy, m_dvalid, m_done;
    logic [15:0] m_dout;

    int errors = 0;
    int checks = 0;

    logic [15:0] frame_words[$];
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];

    always #5 clk = ~clk;

    // Instance a: default 16-bit counter; instance b: 4-bit counter (MAX=15).
    assign din_valid_a  = din_valid & ~sel;
    assign dout_ready_a = dout_ready & ~sel;
    assign din_valid_b  = din_valid & sel;
    assign dout_ready_b = dout_ready & sel;

    assign m_drdy   = sel ? din_ready_b  : din_ready_a;
    assign m_dvalid = sel ? dout_valid_b : dout_valid_a;
    assign m_done   = sel ? done_b       : done_a;
    assign m_dout   = sel ? dout_b       : dout_a;

    run_length_compressor #(.COUNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .Din(Din), .din_valid(din_valid_a), .din_last(din_last),
        .din_ready(din_ready_a), .Dout(dout_a), .dout_valid(dout_valid_a),
        .dout_ready(dout_ready_a), .done(done_a)
    );

    run_length_compressor #(.COUNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .Din(Din), .din_valid(din_valid_b), .din_last(din_last),
        .din_ready(din_ready_b), .Dout(dout_b), .dout_valid(dout_valid_b),
        .dout_ready(dout_ready_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: split the frame's bit stream into maximal runs, then split any run longer than MAX.
    task automatic build_expected();
        bit   bits[$];
        int   maxv;
        int   len;
        bit   cur;
        logic [15:0] w;
        maxv = sel ? 15 : 65535;
        bits = {};
        foreach (frame_words[k]) begin
            w = frame_words[k];
            for (int b = 0; b < 16; b++) bits.push_back(w[b]);
        end
        exp_q = {};
        exp_q.push_back({15'b0, bits[0]});
        cur = bits[0];
        len = 0;
        for (int i = 0; i <= bits.size(); i++) begin
            if (i < bits.size() && bits[i] == cur) begin
                len++;
            end else begin
                while (len > maxv) begin
                    exp_q.push_back(16'(maxv));
                    exp_q.push_back(16'h0000);
                    len -= maxv;
                end
                exp_q.push_back(16'(len));
                if (i < bits.size()) begin
                    cur = bits[i];
                    len = 1;
                end
            end
        end
    endtask

    // Drives frame_words through the selected instance and checks the output stream against exp_q.
    task automatic run_frame(input string name, input int stall_k, input int stall_n,
                             input int vprob, input int rprob);
        int   wi = 0;
        int   outn = 0;
        int   stall_left = stall_n;
        int   cyc = 0;
        bit   fin = 0;
        bit   prev_stall = 0;
        bit   prev_out = 0;
        bit   hdr_pending = 0;
        logic [15:0] prev_dout = '0;
        bit   in_x, out_x;
        int   ncmp;
        act_q = {};
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check($sformatf("%s hold_dout", name), m_dout, prev_dout);
                check($sformatf("%s hold_valid", name), m_dvalid, 1'b1);
            end
            if (m_dvalid) check($sformatf("%s rdy_low_when_pending", name), m_drdy, 1'b0);
            if (hdr_pending) begin
                check($sformatf("%s hdr_latency", name), {m_dvalid, m_dout}, {1'b1, exp_q[0]});
                hdr_pending = 0;
            end
            if (m_done) begin
                check($sformatf("%s done_after_final", name), {prev_out, 16'(outn)},
                      {1'b1, 16'(exp_q.size())});
                fin = 1;
            end
            if (!fin) begin
                din_valid = (wi < frame_words.size()) && ($urandom_range(0, 99) < vprob);
                Din       = (wi < frame_words.size()) ? frame_words[wi] : 16'($urandom);
                din_last  = (wi == frame_words.size() - 1);
                if (m_dvalid && outn == stall_k && stall_left > 0) begin
                    dout_ready = 1'b0;
                    stall_left--;
                end else begin
                    dout_ready = ($urandom_range(0, 99) < rprob);
                end
                in_x  = din_valid && m_drdy;
                out_x = dout_ready && m_dvalid;
                if (in_x && wi == 0) hdr_pending = 1;
                if (in_x) wi++;
                if (out_x) begin
                    act_q.push_back(m_dout);
                    outn++;
                end
                prev_out   = out_x;
                prev_stall = m_dvalid && !dout_ready;
                prev_dout  = m_dout;
            end
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        check($sformatf("%s finished_in_budget", name), fin, 1'b1);
        check($sformatf("%s words_accepted", name), wi, frame_words.size());
        check($sformatf("%s out_count", name), act_q.size(), exp_q.size());
        ncmp = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++)
            check($sformatf("%s word%0d", name, i), act_q[i], exp_q[i]);
        repeat (3) begin
            @(negedge clk);
            check($sformatf("%s done_single_pulse", name), m_done, 1'b0);
        end
    endtask

    initial begin
        int nw;
        logic [15:0] w;
        rst        = 1'b0;
        Din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        sel        = 0;

        // Reset values and din_ready rising one edge after release.
        repeat (2) @(negedge clk);
        check("reset_outputs_a", {din_ready_a, dout_valid_a, done_a, dout_a}, 19'h0);
        check("reset_outputs_b", {din_ready_b, dout_valid_b, done_b, dout_b}, 19'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {din_ready_a, din_ready_b}, 2'b11);

        // Single word with a mid-word transition.
        frame_words = {16'h00FF};
        exp_q = {16'h0001, 16'h0008, 16'h0008};
        run_frame("f00ff", -1, 0, 100, 100);

        // Run crosses a word boundary.
        frame_words = {16'h0000, 16'hFFFF};
        exp_q = {16'h0000, 16'h0010, 16'h0010};
        run_frame("f0000_ffff", -1, 0, 100, 100);

        // Alternating bits: header plus sixteen runs of one.
        frame_words = {16'hAAAA};
        exp_q = {16'h0000};
        for (int i = 0; i < 16; i++) exp_q.push_back(16'h0001);
        run_frame("faaaa", -1, 0, 100, 100);

        // Saturation with a 4-bit counter.
        sel = 1;
        frame_words = {16'hFFFF};
        exp_q = {16'h0001, 16'h000F, 16'h0000, 16'h0001};
        run_frame("sat_ffff", -1, 0, 100, 100);
        sel = 0;

        // Five-cycle stall on the first EMIT.
        frame_words = {16'h00FF};
        exp_q = {16'h0001, 16'h0008, 16'h0008};
        run_frame("stall_00ff", 1, 5, 100, 100);

        // Asynchronous reset in the middle of a frame.
        frame_words = {16'h0F0F};
        Din       = 16'h0F0F;
        din_last  = 1'b1;
        din_valid = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_immediate", {m_drdy, m_dvalid, m_done, m_dout}, 19'h0);
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("ready_low_at_release", m_drdy, 1'b0);
        @(negedge clk);
        check("ready_one_edge_after_release", m_drdy, 1'b1);
        frame_words = {16'h0003};
        exp_q = {16'h0001, 16'h0002, 16'h000E};
        run_frame("after_reset_0003", -1, 0, 100, 100);

        // Random frames on both counter widths with random valid/ready gaps.
        for (int f = 0; f < 14; f++) begin
            sel = ($urandom_range(0, 2) == 0);
            nw  = $urandom_range(1, 4);
            frame_words = {};
            for (int k = 0; k < nw; k++) begin
                case ($urandom_range(0, 3))
                    0:       w = 16'h0000;
                    1:       w = 16'hFFFF;
                    2:       w = 16'($urandom);
                    default: w = 16'($urandom) & 16'($urandom) & 16'($urandom);
                endcase
                frame_words.push_back(w);
            end
            build_expected();
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 6), $urandom_range(0, 4),
                      $urandom_range(40, 100), $urandom_range(40, 100));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
